cryptoveril_decrypt: RTL and testbench
======================================

# cryptoveril_decrypt

Single-clock, three-stage pipelined decryptor that inverts the team's 16-bit shift/mask/offset cipher. It accepts ciphertext words and a 6-bit key over a valid/ready handshake, tracks the per-word cipher state counter in lockstep with the encryptor, and returns plaintext over a second valid/ready handshake. It sits at the receive end of the crypto path, downstream of whatever transports encryptor output.

## Interface
- `WIDTH`, 16: data word width. Fixed at 16; other values are unsupported.
- `clk` input 1: sole clock. All logic updates on the rising edge.
- `rst` input 1: synchronous, active-low reset.
- `in_valid` input 1: ciphertext word presented.
- `in_ready` output 1: decryptor can accept a word this cycle.
- `in_data` input 16: ciphertext word.
- `key_bits` input 6: `[5:3]` is the rotate amount `s`; `[2:1]` is the mask key `k`; `[0]` is ignored. Sampled with each accepted word.
- `resync` input 1: forces the state counter to 0 for the word accepted this cycle.
- `out_valid` output 1: plaintext word valid.
- `out_ready` input 1: downstream accepts the word.
- `out_data` output 16: plaintext word.
- `state` output 2: current state counter value, for debug.

## Operation
- Masks: MASK[0..3] = A5C3, 3C5A, 0FF0, F00E0 is wrong; use the exact values 16'hA5C3, 16'h3C5A, 16'h0FF0, 16'hF00F.
- Encryptor contract: for state `st`, index `idx = st ^ k`, and C = (rotl16(P, s) ^ MASK[idx]) + st, computed mod 2^16.
- State counter `st` is 2 bits and resets to 0. It increments by 1 on every accepted word (`in_valid && in_ready`), wrapping from 3 to 0.
  - If `resync` is high on an accept, that word uses `st = 0` and the counter becomes 1.
  - If `resync` is high with no accept, the counter becomes 0.
- Each accepted word carries `st`, `s` and `k` down the pipeline with it. A key change mid-stream affects only words accepted after the change.
- Stage A: x = C − st, mod 2^16 (wraps on underflow).
- Stage B: y = x ^ MASK[st ^ k].
- Stage C: P = rotr16(y, s). A rotate of 0 passes `y` through unchanged.
- Each stage holds a valid bit. For stage i, ready_i = !valid_i || ready_{i+1}, and ready after stage C is `out_ready`. `in_ready` = ready_A, which is combinational from `out_ready`.
- A stage holds its data while stalled.
- `out_data` and `out_valid` come from the stage C register. They must stay stable while `out_valid && !out_ready`.

## Timing
- Reset while `rst` = 0 at a clock edge:
  - all valid bits, `out_valid`, `out_data` and `state` go to 0;
  - `in_ready` = 1 from the first cycle after reset;
  - in-flight words are discarded.
- Latency: a word accepted at edge N appears on `out_valid` and `out_data` after edge N+3 when there is no backpressure.
- Throughput: one word per cycle while `out_ready` = 1.
- Full pipeline with `out_ready` = 0: `in_ready` = 0 and nothing is lost. The cycle `out_ready` returns to 1, `in_ready` = 1 and all stages advance together.
- Bubbles, meaning cycles with `in_valid` = 0, propagate as `out_valid` = 0 three cycles later. `st` does not advance on bubbles.

## Structure
- Shared package `crypto_pkg` holds:
  - `WIDTH`;
  - the MASK array constant;
  - key field positions, with the rotate field at `[5:3]` and the mask field at `[2:1]`;
  - `rotl16` and `rotr16` functions, shared with the encryptor.
- Sub-module `crypto_pipe_stage`: a generic valid/ready register slice (data plus sideband), instantiated three times. The arithmetic is done in the top module between the slices.

## Test plan
- **Single word.** C=ADFA, key=6'b011_01_0, st=0, out_ready=1 → P=1234 at 3 cycles; `state`=1 afterward.
- **Back-to-back.** ADFA then A5CC, same key, consecutive cycles → 1234 then 0001 on consecutive cycles; `state`=2.
- **Subtract wrap.** Three filler words to bring st=2, then C=0000 with key=0 → P=F00E.
- **Maximum rotate.** C=A5C4, key s=7 k=0, st=0 → P=0E00.
- **Backpressure.**
  - Stream 5 words while holding out_ready=0 for 4 cycles.
  - Required: `in_ready` drops after the pipeline fills, `out_data` stays stable, and all 5 plaintexts emerge in order with none lost or duplicated.
- **Resync and reset.**
  - `resync` on an accept gives the word st=0, and `state` reads 1 next cycle.
  - Reset asserted with 2 words in flight → no output ever appears for them, `out_valid`=0 and `state`=0 the cycle after.

Source files
------------

// File: rtl/crypto_pkg.sv
// Shared definitions for the shift/mask/offset cipher path.
// Holds the data width, the four mask words, the key field positions
// and the 16-bit rotate helpers used by both encryptor and decryptor.
package crypto_pkg;

    localparam int WIDTH = 16;
    localparam int KEY_W = 6;
    localparam int ST_W  = 2;

    // Key layout: [5:3] rotate amount, [2:1] mask key, [0] unused.
    localparam int ROT_HI = 5;
    localparam int ROT_LO = 3;
    localparam int MSK_HI = 2;
    localparam int MSK_LO = 1;

    typedef logic [ST_W-1:0]          st_t;
    typedef logic [ROT_HI-ROT_LO:0]   rot_t;
    typedef logic [MSK_HI-MSK_LO:0]   mkey_t;
    typedef logic signed [WIDTH-1:0]  word_t;

    localparam logic [WIDTH-1:0] MASK [4] = '{16'hA5C3, 16'h3C5A, 16'h0FF0, 16'hF00F};

    function automatic logic [WIDTH-1:0] rotl16(input logic [WIDTH-1:0] v, input rot_t s);
        logic [2*WIDTH-1:0] d;
        d = {v, v} << s;
        return d[2*WIDTH-1:WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] rotr16(input logic [WIDTH-1:0] v, input rot_t s);
        logic [2*WIDTH-1:0] d;
        d = {v, v} >> s;
        return d[WIDTH-1:0];
    endfunction

endpackage

// File: rtl/crypto_pipe_stage.sv
// Generic valid/ready register slice for data plus sideband.
// Ports:
//   clk, rst         clock, synchronous active-low reset
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and registered payload
// The slice accepts whenever it is empty or its content leaves this cycle,
// and holds its payload while stalled.
module crypto_pipe_stage #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic              vld_q;
    logic [DATA_W-1:0] data_q;

    assign in_ready  = !vld_q || out_ready;
    assign out_valid = vld_q;
    assign out_data  = data_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else if (in_ready) begin
            vld_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/cryptoveril_decrypt.sv
// Three-stage pipelined decryptor for the shift/mask/offset cipher.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   in_valid/in_ready/in_data  ciphertext handshake
//   key_bits        [5:3] rotate amount, [2:1] mask key, [0] ignored
//   resync          forces the cipher state of this word (or the counter) to 0
//   out_valid/out_ready/out_data  plaintext handshake
//   state           current cipher state counter (debug)
// Stage A undoes the offset, stage B the mask, stage C the rotate. Each
// word carries its own state and key fields so key changes only affect
// words accepted afterwards.
module cryptoveril_decrypt
    import crypto_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [5:0]       key_bits,
    input  logic             resync,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       state
);

    localparam int A_W = WIDTH + ST_W + $bits(rot_t) + $bits(mkey_t);
    localparam int B_W = WIDTH + $bits(rot_t);

    st_t   st_q;
    st_t   word_st;
    rot_t  key_s;
    mkey_t key_k;
    logic  accept;
    logic  unused_key_lsb;

    logic             vld_p0, vld_p1, vld_p2;
    logic             rdy_p0, rdy_p1, rdy_p2;
    logic [A_W-1:0]   a_in, a_p0;
    logic [B_W-1:0]   b_in, b_p1;
    logic [WIDTH-1:0] c_in, c_p2;

    logic [WIDTH-1:0] x_p0;
    st_t              st_p0;
    rot_t             s_p0;
    mkey_t            k_p0;
    logic [WIDTH-1:0] y_p1;
    rot_t             s_p1;

    assign key_s          = key_bits[ROT_HI:ROT_LO];
    assign key_k          = key_bits[MSK_HI:MSK_LO];
    assign unused_key_lsb = key_bits[0];

    assign in_ready = rdy_p0;
    assign accept   = in_valid && rdy_p0;
    assign word_st  = resync ? st_t'(0) : st_q;
    assign state    = st_q;

    // Cipher state counter: advances once per accepted word, in lockstep
    // with the encryptor; a resync with an accept restarts the sequence
    // at the accepted word, so the counter lands on 1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q <= '0;
        end else if (accept) begin
            st_q <= word_st + st_t'(1);
        end else if (resync) begin
            st_q <= '0;
        end
    end

    // Stage A: remove the additive state offset (mod 2^16).
    assign a_in = {in_data - WIDTH'(word_st), word_st, key_s, key_k};

    crypto_pipe_stage #(.DATA_W(A_W)) u_stage_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (rdy_p0),
        .in_data   (a_in),
        .out_valid (vld_p0),
        .out_ready (rdy_p1),
        .out_data  (a_p0)
    );

    assign {x_p0, st_p0, s_p0, k_p0} = a_p0;

    // Stage B: remove the state/key-selected mask.
    assign b_in = {x_p0 ^ MASK[st_p0 ^ k_p0], s_p0};

    crypto_pipe_stage #(.DATA_W(B_W)) u_stage_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (vld_p0),
        .in_ready  (rdy_p1),
        .in_data   (b_in),
        .out_valid (vld_p1),
        .out_ready (rdy_p2),
        .out_data  (b_p1)
    );

    assign {y_p1, s_p1} = b_p1;

    // Stage C: undo the left rotate; output comes straight from this register.
    assign c_in = rotr16(y_p1, s_p1);

    crypto_pipe_stage #(.DATA_W(WIDTH)) u_stage_c (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (vld_p1),
        .in_ready  (rdy_p2),
        .in_data   (c_in),
        .out_valid (vld_p2),
        .out_ready (out_ready),
        .out_data  (c_p2)
    );

    assign out_valid = vld_p2;
    assign out_data  = c_p2;

endmodule

// File: tb/tb_cryptoveril_decrypt.sv
module tb_cryptoveril_decrypt;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [5:0]  key_bits = '0;
    logic        resync = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [1:0]  state;

    int n_pass = 0;
    int n_total = 0;

    logic [15:0] exp_q[$];
    int          mst = 0;
    int          bp_mode = 0;   // 0: ready, 1: stalled, 2: random

    localparam logic [15:0] M_MASK [4] = '{16'hA5C3, 16'h3C5A, 16'h0FF0, 16'hF00F};

    cryptoveril_decrypt #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .key_bits  (key_bits),
        .resync    (resync),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input bit ok, input logic [15:0] act, input logic [15:0] req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    endtask

    // Reference encryptor, written straight from the cipher definition.
    function automatic logic [15:0] m_encrypt(input logic [15:0] p, input int s, input int k, input int st);
        logic [15:0] r;
        r = 16'((p << s) | (p >> (16 - s)));
        return (r ^ M_MASK[(st ^ k) & 3]) + 16'(st);
    endfunction

    // Downstream ready driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: compares every delivered word with the scoreboard and
    // checks that a stalled output holds.
    bit          prev_stall = 0;
    logic [15:0] prev_data = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 0;
            end else begin
                if (prev_stall)
                    check("stall_hold", out_valid && out_data == prev_data, out_data, prev_data);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 1'b0, out_data, 16'h0);
                    end else begin
                        logic [15:0] e;
                        e = exp_q.pop_front();
                        check("out_data", out_data == e, out_data, e);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    end

    task automatic send_word(input logic [15:0] c, input logic [5:0] key, input bit rs, input logic [15:0] expv);
        bit got;
        in_valid = 1'b1;
        in_data  = c;
        key_bits = key;
        resync   = rs;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
            if (got) exp_q.push_back(expv);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        resync   = 1'b0;
        if (!got) check("accept_timeout", 1'b0, 16'h0, 16'h1);
        mst = rs ? 1 : ((mst + 1) & 3);
    endtask

    task automatic send_plain(input logic [15:0] p, input logic [5:0] key, input bit rs);
        int st;
        st = rs ? 0 : mst;
        send_word(m_encrypt(p, int'(key[5:3]), int'(key[2:1]), st), key, rs, p);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        mst = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic [15:0] p;
        logic [5:0]  key;
        bit          rs;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("reset_out_valid", out_valid == 1'b0, 16'(out_valid), 16'h0);
        check("reset_out_data", out_data == 16'h0, out_data, 16'h0);
        check("reset_state", state == 2'd0, 16'(state), 16'h0);
        check("reset_in_ready", in_ready == 1'b1, 16'(in_ready), 16'h1);

        // Single word and latency.
        send_word(16'hADFA, 6'b011_01_0, 1'b0, 16'h1234);
        @(posedge clk);
        #2;
        check("latency_early", out_valid == 1'b0, 16'(out_valid), 16'h0);
        @(posedge clk);
        #2;
        check("latency_valid", out_valid == 1'b1, 16'(out_valid), 16'h1);
        check("single_word", out_data == 16'h1234, out_data, 16'h1234);
        check("state_after_one", state == 2'd1, 16'(state), 16'h1);

        // Back-to-back words.
        do_reset();
        send_word(16'hADFA, 6'b011_01_0, 1'b0, 16'h1234);
        send_word(16'hA5CC, 6'b011_01_0, 1'b0, 16'h0001);
        @(posedge clk);
        #2;
        check("b2b_first", out_valid && out_data == 16'h1234, out_data, 16'h1234);
        @(posedge clk);
        #2;
        check("b2b_second", out_valid && out_data == 16'h0001, out_data, 16'h0001);
        check("state_after_two", state == 2'd2, 16'(state), 16'h2);

        // Subtract wrap at st=2.
        do_reset();
        send_plain(16'h5555, 6'b001_10_1, 1'b0);
        send_plain(16'h0F0F, 6'b110_01_0, 1'b0);
        send_word(16'h0000, 6'd0, 1'b0, 16'hF00E);

        // Maximum rotate.
        do_reset();
        send_word(16'hA5C4, 6'b111_00_0, 1'b0, 16'h0E00);
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: fill the pipe against a stalled sink.
        do_reset();
        bp_mode = 1;
        @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) send_plain(16'($urandom), 6'($urandom), 1'b0);
        check("bp_in_ready_low", in_ready == 1'b0, 16'(in_ready), 16'h0);
        repeat (2) @(posedge clk);
        #1;
        bp_mode = 0;
        @(posedge clk);
        #2;
        check("bp_in_ready_back", in_ready == 1'b1, 16'(in_ready), 16'h1);
        for (int i = 0; i < 2; i++) send_plain(16'($urandom), 6'($urandom), 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("bp_all_out", exp_q.size() == 0, 16'(exp_q.size()), 16'h0);

        // Resync on an accept, then resync alone.
        send_plain(16'hBEEF, 6'b010_11_0, 1'b0);
        send_plain(16'hCAFE, 6'b101_01_1, 1'b1);
        check("resync_accept_state", state == 2'd1, 16'(state), 16'h1);
        send_plain(16'h7777, 6'b100_10_0, 1'b0);
        resync = 1'b1;
        @(posedge clk);
        #1;
        resync = 1'b0;
        mst = 0;
        check("resync_idle_state", state == 2'd0, 16'(state), 16'h0);
        send_plain(16'h1357, 6'b001_11_0, 1'b0);
        repeat (5) @(posedge clk);
        #1;

        // Reset with two words in flight.
        send_plain(16'hAAAA, 6'b011_01_0, 1'b0);
        send_plain(16'hBBBB, 6'b011_01_0, 1'b0);
        rst = 1'b0;
        exp_q.delete();
        mst = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_flight_valid", out_valid == 1'b0, 16'(out_valid), 16'h0);
        check("rst_flight_state", state == 2'd0, 16'(state), 16'h0);
        repeat (6) @(posedge clk);
        #1;

        // Randomized traffic under random backpressure.
        bp_mode = 2;
        for (int i = 0; i < 150; i++) begin
            p   = 16'($urandom);
            key = 6'($urandom);
            rs  = ($urandom_range(0, 15) == 0);
            send_plain(p, key, rs);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            if (i % 25 == 0)
                check("state_track", int'(state) == mst, 16'(state), 16'(mst));
        end

        bp_mode = 0;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        check("drain_empty", exp_q.size() == 0, 16'(exp_q.size()), 16'h0);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
